// File: rtl/alu_mc_pkg.sv
// Shared ALU encodings, FSM states and saturation helpers (common_params).
// Define ALU_DIV_EN to include the DIV state.
package common_params;

  localparam logic [4:0] F_ADD  = 5'd0;
  localparam logic [4:0] F_SUB  = 5'd1;
  localparam logic [4:0] F_AND  = 5'd2;
  localparam logic [4:0] F_NOR  = 5'd3;
  localparam logic [4:0] F_SLL  = 5'd4;
  localparam logic [4:0] F_SRL  = 5'd5;
  localparam logic [4:0] F_SRA  = 5'd6;
  localparam logic [4:0] F_LHB  = 5'd7;
  localparam logic [4:0] F_NAND = 5'd8;
  localparam logic [4:0] F_OR   = 5'd9;
  localparam logic [4:0] F_NOT  = 5'd10;
  localparam logic [4:0] F_XOR  = 5'd11;
  localparam logic [4:0] F_XNOR = 5'd12;
  localparam logic [4:0] F_UMUL = 5'd13;
  localparam logic [4:0] F_SMUL = 5'd14;
  localparam logic [4:0] F_DIV  = 5'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
`ifdef ALU_DIV_EN
    ST_DIV,
`endif
    ST_MUL
  } state_t;

  typedef enum logic {
    IM_MUL,
    IM_DIV
  } iter_mode_t;

  function automatic logic [63:0] sat_pos(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  function automatic logic [63:0] sat_neg(input int w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iteration engine: shift-add multiply / restoring divide.
// One step per cycle, WIDTH steps per operation.
module alu_mc_iter
  import common_params::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  iter_mode_t       mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] hi_n,
  output logic [WIDTH-1:0] lo_n
);

  localparam int CW = $clog2(WIDTH);

  logic             active;
  logic [CW-1:0]    cnt;
  iter_mode_t       mode_q;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   diff;

  assign sum  = {1'b0, hi}
              + {1'b0, (lo[0] ? b_q : {WIDTH{1'b0}})};
  assign r_sh = {hi, lo[WIDTH-1]};
  assign diff = r_sh - {1'b0, b_q};
  assign done = active && (cnt == CW'(WIDTH - 1));

  // hi:lo is product (mul) or remainder:quotient (div)
  always_comb begin
    hi_n = sum[WIDTH:1];
    lo_n = {sum[0], lo[WIDTH-1:1]};
    if (mode_q == IM_DIV) begin
      hi_n = diff[WIDTH] ? r_sh[WIDTH-1:0]
                         : diff[WIDTH-1:0];
      lo_n = {lo[WIDTH-2:0], ~diff[WIDTH]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
      mode_q <= IM_MUL;
      hi     <= '0;
      lo     <= '0;
      b_q    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= '0;
      mode_q <= mode;
      hi     <= '0;
      lo     <= a;
      b_q    <= b;
    end else if (active) begin
      hi  <= hi_n;
      lo  <= lo_n;
      cnt <= cnt + 1'b1;
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle EX-stage ALU with saturating add/sub and iterative mul/div.
// Define ALU_DIV_EN to build the divider; otherwise DIV is reserved.
module alu_mc
  import common_params::*;
#(
  parameter  int WIDTH = 16,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [4:0]       func,
  input  logic [WIDTH-1:0] src0,
  input  logic [WIDTH-1:0] src1,
  input  logic [SHW-1:0]   shamt,
  output logic             out_vld,
  output logic [WIDTH-1:0] dst,
  output logic             ov,
  output logic             zr,
  output logic             neg,
  output logic             busy
);

  localparam int H = WIDTH / 2;
  localparam logic [WIDTH-1:0] SAT_POS =
    WIDTH'(sat_pos(WIDTH));
  localparam logic [WIDTH-1:0] SAT_NEG =
    WIDTH'(sat_neg(WIDTH));

  state_t           state;
  state_t           state_n;
  logic             accept;
  logic             is_mul;
  logic             is_div;
  logic             start;
  logic             done;
  iter_mode_t       mode;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] hi_n;
  logic [WIDTH-1:0] lo_n;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             add_of;
  logic             sub_of;
  logic [WIDTH-1:0] sc_res;
  logic             sc_ov;
  logic [WIDTH-1:0] mc_res;
  logic             mc_ov;
  logic             mc_smul;
  logic             mc_fix;
  logic [H-1:0]     mag1;
  logic [H-1:0]     mag0;
  logic             sgn;

  assign in_rdy = (state == ST_IDLE);
  assign busy   = ~in_rdy;
  assign accept = in_vld & in_rdy;
  assign zr     = (dst == '0);
  assign neg    = dst[WIDTH-1];
  assign is_mul = (func == F_UMUL) || (func == F_SMUL);
`ifdef ALU_DIV_EN
  assign is_div = (func == F_DIV);
`else
  assign is_div = 1'b0;
`endif

  assign sum    = src1 + src0;
  assign diff   = src1 - src0;
  assign add_of = (src1[WIDTH-1] == src0[WIDTH-1])
               && (sum[WIDTH-1] != src1[WIDTH-1]);
  assign sub_of = (src1[WIDTH-1] != src0[WIDTH-1])
               && (diff[WIDTH-1] != src1[WIDTH-1]);

  always_comb begin
    sc_res = '0;
    sc_ov  = 1'b0;
    case (func)
      F_ADD: begin
        sc_ov  = add_of;
        sc_res = !add_of ? sum
               : (src1[WIDTH-1] ? SAT_NEG : SAT_POS);
      end
      F_SUB: begin
        sc_ov  = sub_of;
        sc_res = !sub_of ? diff
               : (src1[WIDTH-1] ? SAT_NEG : SAT_POS);
      end
      F_AND:  sc_res = src1 & src0;
      F_NOR:  sc_res = ~(src1 | src0);
      F_SLL:  sc_res = src1 << shamt;
      F_SRL:  sc_res = src1 >> shamt;
      F_SRA:  sc_res = $signed(src1) >>> shamt;
      F_LHB:  sc_res = {src1[H-1:0], src0[H-1:0]};
      F_NAND: sc_res = ~(src1 & src0);
      F_OR:   sc_res = src1 | src0;
      F_NOT:  sc_res = ~src1;
      F_XOR:  sc_res = src1 ^ src0;
      F_XNOR: sc_res = ~(src1 ^ src0);
      default: ;
    endcase
  end

  // SMUL multiplies magnitudes; the sign is restored at the end
  assign mag1 = src1[H-1] ? (~src1[H-1:0] + 1'b1)
                          : src1[H-1:0];
  assign mag0 = src0[H-1] ? (~src0[H-1:0] + 1'b1)
                          : src0[H-1:0];
  assign sgn  = src1[H-1] ^ src0[H-1];
  assign op_a = (func == F_SMUL) ? {{H{1'b0}}, mag1} : src1;
  assign op_b = (func == F_SMUL) ? {{H{1'b0}}, mag0} : src0;
  assign mode = is_div ? IM_DIV : IM_MUL;

  alu_mc_iter #(
    .WIDTH(WIDTH)
  ) u_iter (
    .clk  (clk),
    .rst  (rst),
    .start(start),
    .mode (mode),
    .a    (op_a),
    .b    (op_b),
    .done (done),
    .hi_n (hi_n),
    .lo_n (lo_n)
  );

  always_comb begin
    state_n = state;
    start   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          unique case (1'b1)
            is_mul: begin
              state_n = ST_MUL;
              start   = 1'b1;
            end
`ifdef ALU_DIV_EN
            is_div: begin
              state_n = ST_DIV;
              start   = 1'b1;
            end
`endif
            default: ;
          endcase
        end
      end
      ST_MUL: if (done) state_n = ST_IDLE;
`ifdef ALU_DIV_EN
      ST_DIV: if (done) state_n = ST_IDLE;
`endif
      default: state_n = ST_IDLE;
    endcase
  end

  always_comb begin
    mc_res = lo_n;
    mc_ov  = mc_fix;
    if (state == ST_MUL) begin
      if (mc_smul) begin
        mc_res = mc_fix ? (~lo_n + 1'b1) : lo_n;
        mc_ov  = 1'b0;
      end else begin
        mc_ov = |hi_n;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_n;
  end

  // mc_fix: result sign for SMUL, divide-by-zero for DIV
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_vld <= 1'b0;
      dst     <= '0;
      ov      <= 1'b0;
      mc_smul <= 1'b0;
      mc_fix  <= 1'b0;
    end else begin
      out_vld <= 1'b0;
      if (accept) begin
        if (start) begin
          mc_smul <= (func == F_SMUL);
          mc_fix  <= (func == F_SMUL) ? sgn
                                      : (src0 == '0);
        end else begin
          out_vld <= 1'b1;
          dst     <= sc_res;
          ov      <= sc_ov;
        end
      end else if (done) begin
        out_vld <= 1'b1;
        dst     <= mc_res;
        ov      <= mc_ov;
      end
    end
  end

endmodule

// File: tb/tb_alu_mc.sv
// Directed self-checking bench for alu_mc at WIDTH=16.
// Honours ALU_DIV_EN for the DIV expectations.
module tb_alu_mc;
  import common_params::*;

  logic        clk;
  logic        rst;
  logic        in_vld;
  logic        in_rdy;
  logic [4:0]  func;
  logic [15:0] src0;
  logic [15:0] src1;
  logic [3:0]  shamt;
  logic        out_vld;
  logic [15:0] dst;
  logic        ov;
  logic        zr;
  logic        neg;
  logic        busy;

  int n_chk;
  int n_pass;

  alu_mc #(
    .WIDTH(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .in_vld (in_vld),
    .in_rdy (in_rdy),
    .func   (func),
    .src0   (src0),
    .src1   (src1),
    .shamt  (shamt),
    .out_vld(out_vld),
    .dst    (dst),
    .ov     (ov),
    .zr     (zr),
    .neg    (neg),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h",
                  tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0]  f,
                       input logic [15:0] a1,
                       input logic [15:0] a0,
                       input logic [3:0]  sh);
    in_vld = 1'b1;
    func   = f;
    src1   = a1;
    src0   = a0;
    shamt  = sh;
  endtask

  task automatic issue(input logic [4:0]  f,
                       input logic [15:0] a1,
                       input logic [15:0] a0,
                       input logic [3:0]  sh);
    drive(f, a1, a0, sh);
    step();
    in_vld = 1'b0;
    src1   = 16'hDEAD;
    src0   = 16'hBEEF;
  endtask

  // lat counts cycles after accept up to out_vld
  task automatic wait_out(output int lat,
                          output int low);
    lat = 1;
    low = 0;
    while (!out_vld && lat < 40) begin
      if (!in_rdy) low++;
      step();
      lat++;
    end
  endtask

  int lat;
  int low;
  int seen;

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst    = 1'b1;
    in_vld = 1'b0;
    func   = '0;
    src0   = '0;
    src1   = '0;
    shamt  = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    chk("rst_rdy", in_rdy, 1);
    chk("rst_vld", out_vld, 0);
    chk("rst_dst", dst, 0);
    chk("rst_ov", ov, 0);
    chk("rst_zr", zr, 1);
    chk("rst_neg", neg, 0);
    chk("rst_busy", busy, 0);

    issue(F_ADD, 16'h7FFF, 16'h0001, 0);
    chk("add_vld", out_vld, 1);
    chk("add_dst", dst, 16'h7FFF);
    chk("add_ov", ov, 1);
    chk("add_zr", zr, 0);
    chk("add_neg", neg, 0);

    drive(F_SUB, 16'h0005, 16'h0005, 0);
    step();
    chk("sub_vld", out_vld, 1);
    chk("sub_dst", dst, 0);
    chk("sub_zr", zr, 1);
    chk("sub_ov", ov, 0);
    drive(F_SRA, 16'h8000, 16'h0000, 15);
    step();
    in_vld = 1'b0;
    chk("sra_vld", out_vld, 1);
    chk("sra_dst", dst, 16'hFFFF);
    chk("sra_neg", neg, 1);
    step();
    chk("idle_vld", out_vld, 0);

    issue(F_SUB, 16'h8000, 16'h0001, 0);
    chk("subsat_dst", dst, 16'h8000);
    chk("subsat_ov", ov, 1);
    issue(F_SLL, 16'h0001, 16'h0000, 15);
    chk("sll_dst", dst, 16'h8000);
    issue(F_SRL, 16'h8000, 16'h0000, 15);
    chk("srl_dst", dst, 16'h0001);
    issue(F_LHB, 16'h12AB, 16'h34CD, 0);
    chk("lhb_dst", dst, 16'hABCD);
    issue(F_XOR, 16'hF0F0, 16'hFF00, 0);
    chk("xor_dst", dst, 16'h0FF0);
    issue(F_NOR, 16'hF0F0, 16'h0F00, 0);
    chk("nor_dst", dst, 16'h000F);
    issue(5'd31, 16'h1234, 16'h5678, 3);
    chk("rsv_vld", out_vld, 1);
    chk("rsv_dst", dst, 0);
    chk("rsv_zr", zr, 1);

    issue(F_UMUL, 16'h0100, 16'h0100, 0);
    wait_out(lat, low);
    chk("umul_lat", lat, 17);
    chk("umul_low", low, 16);
    chk("umul_dst", dst, 16'h0000);
    chk("umul_ov", ov, 1);
    chk("umul_rdy", in_rdy, 1);
    issue(F_UMUL, 16'h00FF, 16'h0101, 0);
    wait_out(lat, low);
    chk("umul2_dst", dst, 16'hFFFF);
    chk("umul2_ov", ov, 0);
    issue(F_SMUL, 16'h00FD, 16'h0007, 0);
    wait_out(lat, low);
    chk("smul_lat", lat, 17);
    chk("smul_dst", dst, 16'hFFEB);
    chk("smul_ov", ov, 0);
    issue(F_SMUL, 16'hAA80, 16'h5580, 0);
    wait_out(lat, low);
    chk("smul2_dst", dst, 16'h4000);

`ifdef ALU_DIV_EN
    issue(F_DIV, 16'd1000, 16'd7, 0);
    wait_out(lat, low);
    chk("div_lat", lat, 17);
    chk("div_dst", dst, 16'd142);
    chk("div_ov", ov, 0);
    issue(F_DIV, 16'h1234, 16'h0000, 0);
    wait_out(lat, low);
    chk("div0_lat", lat, 17);
    chk("div0_dst", dst, 16'hFFFF);
    chk("div0_ov", ov, 1);
`else
    issue(F_DIV, 16'd1000, 16'd7, 0);
    wait_out(lat, low);
    chk("div_lat", lat, 1);
    chk("div_dst", dst, 0);
    chk("div_ov", ov, 0);
`endif

    issue(F_UMUL, 16'd3, 16'd5, 0);
    drive(F_ADD, 16'd2, 16'd3, 0);
    wait_out(lat, low);
    chk("hold_lat", lat, 17);
    chk("hold_mul", dst, 16'd15);
    chk("hold_rdy", in_rdy, 1);
    step();
    in_vld = 1'b0;
    chk("hold_vld", out_vld, 1);
    chk("hold_add", dst, 16'd5);
    step();
    chk("hold_once", out_vld, 0);

`ifdef ALU_DIV_EN
    issue(F_DIV, 16'd1000, 16'd7, 0);
`else
    issue(F_UMUL, 16'd1000, 16'd7, 0);
`endif
    repeat (4) step();
    chk("abort_busy0", busy, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("abort_rdy", in_rdy, 1);
    chk("abort_dst", dst, 0);
    chk("abort_zr", zr, 1);
    chk("abort_vld", out_vld, 0);
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = 0;
    repeat (25) begin
      step();
      if (out_vld) seen++;
    end
    chk("abort_nopulse", seen, 0);
    issue(F_ADD, 16'd2, 16'd3, 0);
    chk("post_vld", out_vld, 1);
    chk("post_dst", dst, 16'd5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
